simd_fetch_unit: RTL

Per-SIMD instruction fetcher sitting between the SIMD unit's PC and program memory. It reads the current PC, issues a valid/ready read request to program memory and captures the response. It presents the instruction to the decoder and pulses `update_pc` back to the PC when the decoder accepts. One wave per SIMD, no branching; the fetcher starts on wave dispatch and stops when the decoder signals wave end.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_watchdog.sv | 27 ++
 rtl/simd_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the SIMD instruction fetcher.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog: counts WAIT cycles and flags expiry on the last allowed one.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_active,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed WAIT cycles, so the TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1.
  assign o_expired = i_active && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/simd_fetch_unit.sv
// Per-SIMD instruction fetcher: PC -> program memory request -> held instruction for the decoder.
// Optional response watchdog enabled by defining FETCH_TIMEOUT_EN.
module simd_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_WIDTH = FETCH_ADDR_W,
  parameter int unsigned INSTR_WIDTH            = FETCH_INSTR_W,
  parameter int unsigned TIMEOUT_CYCLES         = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              start,
  input  logic                              done,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
  output logic                              update_pc,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                              mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]            mem_rsp_data,
  output logic                              instr_valid,
  output logic [INSTR_WIDTH-1:0]            instr,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] instr_pc,
  input  logic                              instr_ready,
  output logic                              busy,
  output logic                              fetch_err
);

  fetch_state_t                      r_state;
  logic                              r_instr_valid;
  logic [INSTR_WIDTH-1:0]            r_instr;
  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] r_instr_pc;
  logic                              r_fetch_err;

  logic w_launch;
  logic w_handshake;
  logic w_accept;
  logic w_timeout;

  assign w_launch    = (r_state == IDLE) && start && enable;
  assign w_handshake = (r_state == REQ) && mem_req_ready;
  assign w_accept    = (r_state == HOLD) && r_instr_valid && instr_ready && enable;

`ifdef FETCH_TIMEOUT_EN
  logic w_expired;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_handshake),
    .i_active (r_state == WAIT),
    .o_expired(w_expired)
  );

  // A response arriving on the expiry cycle still wins over the timeout.
  assign w_timeout = w_expired && !mem_rsp_valid;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_state     <= REQ;
            r_fetch_err <= 1'b0;
          end
        end
        REQ: begin
          if (w_handshake) begin
            r_state    <= WAIT;
            r_instr_pc <= pc_in;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state       <= HOLD;
            r_instr       <= mem_rsp_data;
            r_instr_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state     <= IDLE;
            r_fetch_err <= 1'b1;
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_instr_valid <= 1'b0;
            r_state       <= done ? IDLE : REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // pc_in only moves on update_pc, which is confined to HOLD, so it is stable across REQ.
  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = mem_req_valid ? pc_in : '0;
  assign update_pc     = w_accept;
  assign busy          = (r_state != IDLE);
  assign instr_valid   = r_instr_valid;
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign fetch_err     = r_fetch_err;

endmodule
